// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bundle: D/E/M stage hazard inputs
// and the stall, flush, MDU busy and performance outputs.
interface hazard_stall_ctrl_if;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic [1:0]  tuseRsD;
    logic [1:0]  tuseRtD;
    logic        regWriteE;
    logic [4:0]  regAddrE;
    logic [1:0]  tnewE;
    logic        regWriteM;
    logic [4:0]  regAddrM;
    logic [1:0]  tnewM;
    logic        mduUseD;
    logic        mduStartE;
    logic        mduIsDivE;
    logic        stallF;
    logic        stallD;
    logic        flushE;
    logic        mduBusy;
    logic [31:0] stallCount;

    modport master (
        output rsD, rtD, tuseRsD, tuseRtD,
        output regWriteE, regAddrE, tnewE,
        output regWriteM, regAddrM, tnewM,
        output mduUseD, mduStartE, mduIsDivE,
        input  stallF, stallD, flushE,
        input  mduBusy, stallCount
    );

    modport slave (
        input  rsD, rtD, tuseRsD, tuseRtD,
        input  regWriteE, regAddrE, tnewE,
        input  regWriteM, regAddrM, tnewM,
        input  mduUseD, mduStartE, mduIsDivE,
        output stallF, stallD, flushE,
        output mduBusy, stallCount
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Tuse/Tnew data-hazard and MDU-busy stall controller for the
// 5-stage MIPS pipeline, with a saturating stalled-cycle counter.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);

    logic [CNT_W-1:0] r_mdu_cnt;
    logic [31:0]      r_stall_cnt;
    logic             w_rs_e;
    logic             w_rs_m;
    logic             w_rt_e;
    logic             w_rt_m;
    logic             w_data_stall;
    logic             w_mdu_busy;
    logic             w_mdu_stall;
    logic             w_stall;

    // Source/destination match where the value is needed
    // before the producing stage can deliver it.
    always_comb begin
        w_rs_e = bus.regWriteE
              && (bus.rsD != 5'd0)
              && (bus.tuseRsD != 2'd3)
              && (bus.rsD == bus.regAddrE)
              && (bus.tuseRsD < bus.tnewE);
        w_rs_m = bus.regWriteM
              && (bus.rsD != 5'd0)
              && (bus.tuseRsD != 2'd3)
              && (bus.rsD == bus.regAddrM)
              && (bus.tuseRsD < bus.tnewM);
        w_rt_e = bus.regWriteE
              && (bus.rtD != 5'd0)
              && (bus.tuseRtD != 2'd3)
              && (bus.rtD == bus.regAddrE)
              && (bus.tuseRtD < bus.tnewE);
        w_rt_m = bus.regWriteM
              && (bus.rtD != 5'd0)
              && (bus.tuseRtD != 2'd3)
              && (bus.rtD == bus.regAddrM)
              && (bus.tuseRtD < bus.tnewM);
        w_data_stall = w_rs_e || w_rs_m
                    || w_rt_e || w_rt_m;
    end

    assign w_mdu_busy  = (r_mdu_cnt != '0);
    assign w_mdu_stall = bus.mduUseD
                      && (w_mdu_busy || bus.mduStartE);
    // Outputs are forced low while reset is held.
    assign w_stall     = reset
                      && (w_data_stall || w_mdu_stall);

    // MDU busy window: load on start (restart if busy),
    // then count down to zero and hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mdu_cnt <= '0;
        end else if (bus.mduStartE) begin
            r_mdu_cnt <= bus.mduIsDivE
                       ? CNT_W'(DIV_CYCLES)
                       : CNT_W'(MULT_CYCLES);
        end else if (w_mdu_busy) begin
            r_mdu_cnt <= r_mdu_cnt - 1'b1;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stallF     = w_stall;
    assign bus.stallD     = w_stall;
    assign bus.flushE     = w_stall;
    assign bus.mduBusy    = w_mdu_busy;
    assign bus.stallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, directed MDU/reset/
// saturation sequences and a randomized run against a model.
module tb_hazard_stall_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_stall_ctrl_if bus();

    hazard_stall_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES(10),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tu_rs;
        logic [1:0] tu_rt;
        logic       we;
        logic [4:0] ae;
        logic [1:0] tne;
        logic       wm;
        logic [4:0] am;
        logic [1:0] tnm;
        logic       exp_stall;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic idle();
        bus.rsD       = 5'd0;
        bus.rtD       = 5'd0;
        bus.tuseRsD   = 2'd3;
        bus.tuseRtD   = 2'd3;
        bus.regWriteE = 1'b0;
        bus.regAddrE  = 5'd0;
        bus.tnewE     = 2'd0;
        bus.regWriteM = 1'b0;
        bus.regAddrM  = 5'd0;
        bus.tnewM     = 2'd0;
        bus.mduUseD   = 1'b0;
        bus.mduStartE = 1'b0;
        bus.mduIsDivE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic check_stall(input string name,
                               input logic exp);
        check({name, ".stallF"}, 32'(bus.stallF), 32'(exp));
        check({name, ".stallD"}, 32'(bus.stallD), 32'(exp));
        check({name, ".flushE"}, 32'(bus.flushE), 32'(exp));
    endtask

    // Reference rule: any source read too early against any
    // writing stage whose result is not ready yet.
    function automatic logic ref_data_stall(
        input logic [4:0] rs, input logic [4:0] rt,
        input logic [1:0] tu_rs, input logic [1:0] tu_rt,
        input logic we, input logic [4:0] ae,
        input logic [1:0] tne,
        input logic wm, input logic [4:0] am,
        input logic [1:0] tnm);
        logic [4:0] src[2];
        int         tu[2];
        logic       wr[2];
        logic [4:0] dst[2];
        int         tn[2];
        logic       hit;
        src = '{rs, rt};
        tu  = '{int'(tu_rs), int'(tu_rt)};
        wr  = '{we, wm};
        dst = '{ae, am};
        tn  = '{int'(tne), int'(tnm)};
        hit = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int d = 0; d < 2; d++)
                if (src[s] != 0 && tu[s] != 3 && wr[d]
                    && src[s] == dst[d] && tu[s] < tn[d])
                    hit = 1'b1;
        return hit;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle();

        tbl[0] = '{5'd8, 5'd0, 2'd1, 2'd3,
                   1'b1, 5'd8, 2'd2, 1'b0, 5'd0, 2'd0, 1'b1};
        tbl[1] = '{5'd8, 5'd0, 2'd2, 2'd3,
                   1'b1, 5'd8, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0};
        tbl[2] = '{5'd0, 5'd0, 2'd0, 2'd3,
                   1'b1, 5'd0, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0};
        tbl[3] = '{5'd9, 5'd0, 2'd3, 2'd3,
                   1'b1, 5'd9, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0};
        tbl[4] = '{5'd0, 5'd5, 2'd3, 2'd0,
                   1'b0, 5'd0, 2'd0, 1'b1, 5'd5, 2'd1, 1'b1};
        tbl[5] = '{5'd0, 5'd5, 2'd3, 2'd0,
                   1'b0, 5'd0, 2'd0, 1'b0, 5'd5, 2'd1, 1'b0};
        tbl[6] = '{5'd4, 5'd0, 2'd0, 2'd3,
                   1'b1, 5'd4, 2'd1, 1'b0, 5'd0, 2'd0, 1'b1};
        tbl[7] = '{5'd4, 5'd0, 2'd0, 2'd3,
                   1'b1, 5'd4, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0};
        tbl[8] = '{5'd0, 5'd7, 2'd3, 2'd1,
                   1'b1, 5'd6, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0};
        tbl[9] = '{5'd0, 5'd7, 2'd3, 2'd0,
                   1'b0, 5'd0, 2'd0, 1'b1, 5'd7, 2'd0, 1'b0};

        // Reset state, with a hazard present on the inputs.
        bus.rsD = 5'd8; bus.tuseRsD = 2'd0;
        bus.regWriteE = 1'b1; bus.regAddrE = 5'd8;
        bus.tnewE = 2'd2; bus.mduUseD = 1'b1;
        bus.mduStartE = 1'b1;
        repeat (2) tick();
        check_stall("rst", 1'b0);
        check("rst.busy", 32'(bus.mduBusy), 32'd0);
        check("rst.cnt", bus.stallCount, 32'd0);
        idle();
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Combinational data-hazard vectors.
        for (int i = 0; i < 10; i++) begin
            bus.rsD       = tbl[i].rs;
            bus.rtD       = tbl[i].rt;
            bus.tuseRsD   = tbl[i].tu_rs;
            bus.tuseRtD   = tbl[i].tu_rt;
            bus.regWriteE = tbl[i].we;
            bus.regAddrE  = tbl[i].ae;
            bus.tnewE     = tbl[i].tne;
            bus.regWriteM = tbl[i].wm;
            bus.regAddrM  = tbl[i].am;
            bus.tnewM     = tbl[i].tnm;
            @(negedge clk);
            check_stall($sformatf("vec%0d", i),
                        tbl[i].exp_stall);
        end
        idle();

        // lw in E then M: one stall cycle.
        do_reset();
        bus.rsD = 5'd8; bus.tuseRsD = 2'd1;
        bus.regWriteE = 1'b1; bus.regAddrE = 5'd8;
        bus.tnewE = 2'd2;
        @(negedge clk);
        check_stall("lw.E", 1'b1);
        tick();
        bus.regWriteE = 1'b0; bus.regAddrE = 5'd0;
        bus.tnewE = 2'd0;
        bus.regWriteM = 1'b1; bus.regAddrM = 5'd8;
        bus.tnewM = 2'd1;
        @(negedge clk);
        check_stall("lw.M", 1'b0);
        check("lw.cnt", bus.stallCount, 32'd1);
        idle();

        // mult start with mfhi waiting in D.
        do_reset();
        bus.mduUseD = 1'b1;
        bus.mduStartE = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            check_stall($sformatf("mul.t%0d", k), k <= 5);
            check($sformatf("mul.busy.t%0d", k),
                  32'(bus.mduBusy), 32'(k >= 1 && k <= 5));
            tick();
            bus.mduStartE = 1'b0;
        end
        check("mul.cnt", bus.stallCount, 32'd6);
        idle();

        // div start, no MDU user in D.
        do_reset();
        bus.mduStartE = 1'b1;
        bus.mduIsDivE = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            check_stall($sformatf("div.t%0d", k), 1'b0);
            check($sformatf("div.busy.t%0d", k),
                  32'(bus.mduBusy), 32'(k >= 1 && k <= 10));
            tick();
            bus.mduStartE = 1'b0;
        end
        idle();

        // Reset pulsed mid-div.
        do_reset();
        bus.mduStartE = 1'b1;
        bus.mduIsDivE = 1'b1;
        tick();
        idle();
        bus.mduUseD = 1'b1;
        repeat (3) tick();
        check("mid.busy", 32'(bus.mduBusy), 32'd1);
        check("mid.cnt", bus.stallCount, 32'd3);
        #1;
        reset = 1'b0;
        #1;
        check("mid.rst.busy", 32'(bus.mduBusy), 32'd0);
        check("mid.rst.cnt", bus.stallCount, 32'd0);
        check_stall("mid.rst", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_stall("mid.rel", 1'b0);
        tick();
        check_stall("mid.rel2", 1'b0);
        check("mid.rel.cnt", bus.stallCount, 32'd0);
        idle();

        // Saturation of the stalled-cycle counter.
        do_reset();
        bus.rsD = 5'd3; bus.tuseRsD = 2'd0;
        bus.regWriteM = 1'b1; bus.regAddrM = 5'd3;
        bus.tnewM = 2'd1;
        @(negedge clk);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_stall($sformatf("sat.stall%0d", k), 1'b1);
            check($sformatf("sat.cnt%0d", k),
                  bus.stallCount, 32'hFFFF_FFFF);
        end
        idle();

        // Randomized run against a cycle-indexed model.
        do_reset();
        begin
            int          cyc;
            int          busy_end;
            longint      scount;
            logic        exp_busy;
            logic        exp_stall;
            cyc      = 0;
            busy_end = -1;
            scount   = 0;
            for (int n = 0; n < 2000; n++) begin
                bus.rsD       = 5'($urandom_range(0, 3));
                bus.rtD       = 5'($urandom_range(0, 3));
                bus.tuseRsD   = 2'($urandom_range(0, 3));
                bus.tuseRtD   = 2'($urandom_range(0, 3));
                bus.regWriteE = 1'($urandom_range(0, 1));
                bus.regAddrE  = 5'($urandom_range(0, 3));
                bus.tnewE     = 2'($urandom_range(0, 2));
                bus.regWriteM = 1'($urandom_range(0, 1));
                bus.regAddrM  = 5'($urandom_range(0, 3));
                bus.tnewM     = 2'($urandom_range(0, 1));
                bus.mduUseD   = ($urandom_range(0, 9) < 3);
                bus.mduStartE = ($urandom_range(0, 19) == 0);
                bus.mduIsDivE = 1'($urandom_range(0, 1));
                @(negedge clk);
                exp_busy  = (cyc <= busy_end);
                exp_stall = ref_data_stall(
                    bus.rsD, bus.rtD, bus.tuseRsD, bus.tuseRtD,
                    bus.regWriteE, bus.regAddrE, bus.tnewE,
                    bus.regWriteM, bus.regAddrM, bus.tnewM)
                    || (bus.mduUseD
                        && (exp_busy || bus.mduStartE));
                check_stall($sformatf("rnd%0d", n), exp_stall);
                check($sformatf("rnd%0d.busy", n),
                      32'(bus.mduBusy), 32'(exp_busy));
                check($sformatf("rnd%0d.cnt", n),
                      bus.stallCount, 32'(scount));
                if (bus.mduStartE)
                    busy_end = cyc + (bus.mduIsDivE ? 10 : 5);
                if (exp_stall && scount < 64'hFFFF_FFFF)
                    scount++;
                cyc++;
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Compares D-stage source registers against the E and M stage destinations using Tuse/Tnew timing, and tracks the busy window of the multi-cycle mult/div unit (MDU).
- Drives stall of the PC and IF/ID registers and flush (bubble insertion) of the ID/EX register.
- The pipeline registers downstream, including MEM/WB, then carry bubbles forward.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the MDU busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rsD  input  5  rs field of the D-stage instruction.
- rtD  input  5  rt field of the D-stage instruction.
- tuseRsD  input  2  cycles until rs is needed (0,1,2); 3 = not read.
- tuseRtD  input  2  same for rt.
- regWriteE  input  1  E-stage instruction writes the GPR file.
- regAddrE  input  5  E-stage destination register.
- tnewE  input  2  cycles until the E-stage result is available (0..2).
- regWriteM  input  1  M-stage instruction writes the GPR file.
- regAddrM  input  5  M-stage destination register.
- tnewM  input  2  cycles until the M-stage result is available (0..1).
- mduUseD  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- mduStartE  input  1  E-stage instruction starts the MDU this cycle.
- mduIsDivE  input  1  with mduStartE: 1 = div/divu, 0 = mult/multu.
- stallF  output  1  hold PC.
- stallD  output  1  hold the IF/ID register.
- flushE  output  1  load a bubble into ID/EX.
- mduBusy  output  1  MDU counter nonzero (registered).
- stallCount  output  32  saturating performance counter of stalled cycles.

Behaviour:
- Reset (reset=0, asynchronous): busy counter = 0, mduBusy = 0, stallCount = 0. Reset mid-MDU operation aborts the busy window immediately. With reset asserted, stallF/stallD/flushE = 0.
- Data stall: stall on a source register r in {rs, rt} when all of the following hold:
  - r != 0;
  - its tuse is not 3;
  - it matches regAddrX for X in {E, M} with regWriteX = 1;
  - its tuse < tnewX.
- Register $0 never stalls. tuse = 3 never stalls.
- MDU counter:
  - On a rising edge with mduStartE = 1, load DIV_CYCLES if mduIsDivE, else MULT_CYCLES.
  - Otherwise decrement when nonzero; hold at 0.
  - A start while the counter is nonzero reloads it (restart).
  - mduBusy = (counter != 0), registered.
- MDU stall: mduUseD and (mduBusy or mduStartE).
- stall = data stall OR MDU stall, combinational from inputs and the registered counter.
- stallF = stallD = flushE = stall.
- MDU timing: start in E at cycle t with N busy cycles. mduBusy is high in cycles t+1..t+N. A waiting MDU instruction in D is stalled in cycles t..t+N, which is N+1 cycles, and advances at t+N+1.
- stallCount: increments on each rising edge where stall = 1. It saturates at 0xFFFFFFFF and does not wrap.
- Simultaneous data and MDU stall: single stall. stallCount increments by 1.
- No registered outputs other than mduBusy and stallCount. No internal state beyond the counter and stallCount.

Test Plan:
- lw $t0 in E (regWriteE=1, regAddrE=8, tnewE=2); D has rsD=8, tuseRsD=1 -> stall=1 that cycle. Next cycle the load is in M with tnewM=1 -> stall=0. stallCount=1.
- regAddrE=0, regWriteE=1, tnewE=2, rsD=0, tuseRsD=0 -> stall=0. rsD=9 with tuseRsD=3 matching regAddrE=9 -> stall=0.
- mduStartE=1, mduIsDivE=0 at cycle t; mfhi in D from cycle t -> stall high in cycles t..t+5 and low at t+6. mduBusy high in t+1..t+5. stallCount=6.
- div start (mduIsDivE=1) -> mduBusy high for exactly 10 cycles. mduUseD=0 throughout -> stall never asserted.
- div started, counter at 7, then reset pulsed low asynchronously -> mduBusy=0 and stallCount=0 immediately. A pending mduUseD instruction is not stalled after release.
- Force stallCount to 0xFFFFFFFE, hold stall for 3 cycles -> stallCount = 0xFFFFFFFF and stays there.
